jtag_dr_bank: RTL and testbench

JTAG_DR_BANK -- requirements
Module: jtag_dr_bank

---
 rtl/jtag_dr_bank.sv | 143 ++++++++++++++
 tb/tb_jtag_dr_bank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dr_bank.sv
// Bank of independent JTAG user data-register chains with length-checked update.
// Optional capture_in readback on capture is enabled by defining JTAG_DR_READBACK_EN.
module jtag_dr_bank #(
  parameter int unsigned NUM_CHAINS = 2,
  parameter int unsigned DR_WIDTH   = 30,
  parameter logic [DR_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           JTCK,
  input  logic                           JRST,
  input  logic                           JTDI,
  input  logic                           JSHIFT,
  input  logic                           JUPDATE,
  input  logic [NUM_CHAINS-1:0]          JCE,
  input  logic [NUM_CHAINS-1:0]          JRTI,
  input  logic [NUM_CHAINS*DR_WIDTH-1:0] capture_in,
  output logic [NUM_CHAINS-1:0]          JTDO,
  output logic [NUM_CHAINS*DR_WIDTH-1:0] dr_out,
  output logic [NUM_CHAINS-1:0]          update_strobe,
  output logic [NUM_CHAINS-1:0]          rti_strobe,
  output logic [NUM_CHAINS-1:0]          len_error
);

  localparam int unsigned CW = $clog2(DR_WIDTH + 2);
  localparam logic [CW-1:0] C_FULL = CW'(DR_WIDTH);
  localparam logic [CW-1:0] C_SAT  = CW'(DR_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFTING, S_ARMED} state_t;

  logic                  r_rst_q;
  state_t                r_state   [NUM_CHAINS];
  state_t                w_next    [NUM_CHAINS];
  logic [DR_WIDTH-1:0]   r_sr      [NUM_CHAINS];
  logic [DR_WIDTH-1:0]   r_dr      [NUM_CHAINS];
  logic [DR_WIDTH-1:0]   w_cap_val [NUM_CHAINS];
  logic [CW-1:0]         r_cnt     [NUM_CHAINS];
  logic [NUM_CHAINS-1:0] w_sel, w_cap, w_shift, w_upd_ok, w_upd_bad;
  logic [NUM_CHAINS-1:0] r_upd_stb, r_rti_q, r_rti_stb, r_len_err;

  // Assert follows JRST immediately; release is held for one JTCK edge.
  always_ff @(posedge JTCK or posedge JRST) begin
    if (JRST) r_rst_q <= 1'b1;
    else      r_rst_q <= 1'b0;
  end

  // Lowest-index enabled chain wins; scanning downward lets it overwrite.
  always_comb begin
    w_sel = '0;
    for (int unsigned i = NUM_CHAINS; i > 0; i--) begin
      if (JCE[i-1]) w_sel = NUM_CHAINS'(1) << (i - 1);
    end
  end

`ifdef JTAG_DR_READBACK_EN
  always_comb begin
    for (int unsigned i = 0; i < NUM_CHAINS; i++)
      w_cap_val[i] = capture_in[i*DR_WIDTH +: DR_WIDTH];
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < NUM_CHAINS; i++)
      w_cap_val[i] = r_dr[i];
  end
  logic w_unused_capture;
  assign w_unused_capture = ^capture_in;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NUM_CHAINS; i++) begin
      w_next[i]    = r_state[i];
      w_cap[i]     = 1'b0;
      w_shift[i]   = 1'b0;
      w_upd_ok[i]  = 1'b0;
      w_upd_bad[i] = 1'b0;
      if (w_sel[i] && !JSHIFT) begin
        w_cap[i]  = 1'b1;
        w_next[i] = S_SHIFTING;
      end else begin
        case (r_state[i])
          S_SHIFTING: begin
            if (w_sel[i])     w_shift[i] = 1'b1;
            else if (!JCE[i]) w_next[i]  = S_ARMED;
          end
          S_ARMED: begin
            if (JUPDATE) begin
              w_next[i] = S_IDLE;
              if (r_cnt[i] == C_FULL) w_upd_ok[i]  = 1'b1;
              else                    w_upd_bad[i] = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge JTCK or posedge r_rst_q) begin
    if (r_rst_q) begin
      for (int unsigned i = 0; i < NUM_CHAINS; i++) begin
        r_state[i] <= S_IDLE;
        r_sr[i]    <= '0;
        r_cnt[i]   <= '0;
        r_dr[i]    <= RESET_VALUE;
      end
      r_upd_stb <= '0;
      r_rti_q   <= '0;
      r_rti_stb <= '0;
      r_len_err <= '0;
    end else begin
      r_rti_q   <= JRTI;
      r_rti_stb <= JRTI & ~r_rti_q;
      r_upd_stb <= w_upd_ok;
      for (int unsigned i = 0; i < NUM_CHAINS; i++) begin
        r_state[i] <= w_next[i];
        if (w_cap[i]) begin
          r_sr[i]  <= w_cap_val[i];
          r_cnt[i] <= '0;
        end else if (w_shift[i]) begin
          r_sr[i] <= {JTDI, r_sr[i][DR_WIDTH-1:1]};
          if (r_cnt[i] != C_SAT) r_cnt[i] <= r_cnt[i] + CW'(1);
        end
        if (w_upd_ok[i]) begin
          r_dr[i]      <= r_sr[i];
          r_len_err[i] <= 1'b0;
        end
        if (w_upd_bad[i]) r_len_err[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    JTDO   = '0;
    dr_out = '0;
    for (int unsigned i = 0; i < NUM_CHAINS; i++) begin
      JTDO[i]                            = r_sr[i][0];
      dr_out[i*DR_WIDTH +: DR_WIDTH]     = r_dr[i];
    end
  end

  assign update_strobe = r_upd_stb;
  assign rti_strobe    = r_rti_stb;
  assign len_error     = r_len_err;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Randomized bench for jtag_dr_bank against a transaction-level reference model.
module tb_jtag_dr_bank;

  localparam logic [29:0] RV = 30'h155;

  logic        JTCK = 1'b0;
  logic        JRST, JTDI, JSHIFT, JUPDATE;
  logic [1:0]  JCE, JRTI;
  logic [59:0] capture_in;
  logic [1:0]  JTDO, update_strobe, rti_strobe, len_error;
  logic [59:0] dr_out;

  jtag_dr_bank #(.NUM_CHAINS(2), .DR_WIDTH(30), .RESET_VALUE(RV)) dut (
    .JTCK(JTCK), .JRST(JRST), .JTDI(JTDI), .JSHIFT(JSHIFT), .JUPDATE(JUPDATE),
    .JCE(JCE), .JRTI(JRTI), .capture_in(capture_in), .JTDO(JTDO),
    .dr_out(dr_out), .update_strobe(update_strobe), .rti_strobe(rti_strobe),
    .len_error(len_error)
  );

  always #5 JTCK = ~JTCK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [29:0] m_dr [2];
  logic [1:0]  m_err;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge JTCK);
    @(negedge JTCK);
  endtask

  task automatic check_model(input string tag);
    check_val({tag, "_dr"}, dr_out, {m_dr[1], m_dr[0]});
    check_val({tag, "_err"}, len_error, m_err);
  endtask

  task automatic idle_inputs();
    JCE = 2'b00; JSHIFT = 1'b0; JUPDATE = 1'b0; JTDI = 1'b0;
  endtask

  task automatic release_reset();
    JRST = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    JRTI = 2'b00;
    JRST = 1'b1;
    m_dr[0] = RV; m_dr[1] = RV; m_err = 2'b00;
    tick();
    check_val("rst_dr", dr_out, {RV, RV});
    check_val("rst_upd", update_strobe, 2'b00);
    check_val("rst_rti", rti_strobe, 2'b00);
    check_val("rst_err", len_error, 2'b00);
    check_val("rst_tdo", JTDO, 2'b00);
    release_reset();
  endtask

  // Capture, shift n bits of data, leave the chain, then pulse update.
  task automatic run_txn(input int c, input logic [1:0] ce, input int n,
                         input logic [63:0] data, input logic [59:0] cin);
    logic [29:0] cap;
    logic        exp_bit;
    capture_in = cin;
`ifdef JTAG_DR_READBACK_EN
    cap = cin[c*30 +: 30];
`else
    cap = m_dr[c];
`endif
    JCE = ce; JSHIFT = 1'b0; JUPDATE = 1'b0;
    tick();
    for (int k = 0; k <= n; k++) begin
      exp_bit = (k < 30) ? cap[k] : data[k-30];
      check_val($sformatf("tdo_c%0d_b%0d", c, k), 64'(JTDO[c]), 64'(exp_bit));
      if (k < n) begin
        JSHIFT = 1'b1; JTDI = data[k];
        tick();
      end
    end
    JCE = 2'b00; JSHIFT = 1'b0;
    tick();
    JUPDATE = 1'b1;
    tick();
    JUPDATE = 1'b0;
    if (n == 30) begin
      m_dr[c]  = data[29:0];
      m_err[c] = 1'b0;
    end else begin
      m_err[c] = 1'b1;
    end
    check_val($sformatf("upd_stb_c%0d", c), update_strobe,
              (n == 30) ? (64'd1 << c) : 64'd0);
    check_model($sformatf("txn_c%0d_n%0d", c, n));
    tick();
    check_val("upd_stb_off", update_strobe, 2'b00);
  endtask

  function automatic logic [59:0] rand60();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] d;
    logic [59:0] cin;
    logic [1:0]  last_rti;
    int          c, n;
    int          lens [6] = '{29, 30, 31, 35, 30, 30};

    JRST = 1'b1; JRTI = 2'b00; capture_in = '0;
    idle_inputs();
    @(negedge JTCK);
    do_reset();

    // Update pulse with nothing armed
    JUPDATE = 1'b1;
    tick();
    JUPDATE = 1'b0;
    check_val("noarm_stb", update_strobe, 2'b00);
    check_model("noarm");

    run_txn(0, 2'b01, 30, 64'h2AAAAAAA, rand60());
    run_txn(1, 2'b10, 29, {$urandom, $urandom}, rand60());
    run_txn(1, 2'b10, 30, {$urandom, $urandom}, rand60());

    cin = rand60();
    cin[29:0] = 30'h0000_1234;
    run_txn(0, 2'b01, 30, {$urandom, $urandom}, cin);

    // Both enables high: chain 0 owns the transaction
    run_txn(0, 2'b11, 30, {$urandom, $urandom}, rand60());

    // Capture coinciding with update discards the pending update
    JCE = 2'b01; JSHIFT = 1'b0;
    tick();
    JSHIFT = 1'b1;
    for (int k = 0; k < 30; k++) begin
      JTDI = 1'($urandom);
      tick();
    end
    JCE = 2'b00; JSHIFT = 1'b0;
    tick();
    JCE = 2'b01; JUPDATE = 1'b1;
    tick();
    check_val("capwin_stb", update_strobe, 2'b00);
    check_model("capwin");
    JCE = 2'b00; JUPDATE = 1'b0;
    tick();
    JUPDATE = 1'b1;
    tick();
    JUPDATE = 1'b0;
    m_err[0] = 1'b1;
    check_val("capwin_len_stb", update_strobe, 2'b00);
    check_model("capwin_len");

    for (int t = 0; t < 16; t++) begin
      c = $urandom_range(0, 1);
      n = lens[$urandom_range(0, 5)];
      d = {$urandom, $urandom};
      run_txn(c, (c == 0) ? 2'($urandom_range(1, 2) == 1 ? 2'b01 : 2'b11) : 2'b10,
              n, d, rand60());
    end

    last_rti = 2'b00;
    for (int t = 0; t < 24; t++) begin
      JRTI = 2'($urandom_range(0, 3));
      tick();
      check_val($sformatf("rti_%0d", t), rti_strobe, JRTI & ~last_rti);
      last_rti = JRTI;
    end
    JRTI = 2'b00;
    tick();

    // Abort a contended transaction with reset after 10 shift bits
    JCE = 2'b11; JSHIFT = 1'b0;
    tick();
    JSHIFT = 1'b1;
    for (int k = 0; k < 10; k++) begin
      JTDI = 1'($urandom);
      tick();
    end
    JRST = 1'b1;
    #1;
    m_dr[0] = RV; m_dr[1] = RV; m_err = 2'b00;
    check_val("abort_dr", dr_out, {RV, RV});
    check_val("abort_tdo", JTDO, 2'b00);
    idle_inputs();
    tick();
    release_reset();
    tick();
    JUPDATE = 1'b1;
    tick();
    JUPDATE = 1'b0;
    check_val("abort_upd_stb", update_strobe, 2'b00);
    check_model("abort_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
